// File: rtl/wb_regfile_scoreboard_if.sv
// Bundle of writeback, decode-read and issue signals between the pipeline and the
// register file / scoreboard.
interface wb_regfile_scoreboard_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
);
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_a;
  logic              busy_b;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_stall;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output wb_en, wb_addr, wb_data, rd_addr_a, rd_addr_b, issue_en, issue_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, issue_stall, pending_cnt
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, rd_addr_a, rd_addr_b, issue_en, issue_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, issue_stall, pending_cnt
  );
endinterface

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file fed by MEM/WB, with write-through read ports and a
// one-writer-per-register busy scoreboard for decode hazard stalls.
module wb_regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 7,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic clk,
  input logic rst,
  wb_regfile_scoreboard_if.slave bus
);
  localparam int unsigned NRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NRegs];
  logic [NRegs-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wb_zero, issue_zero, rd_zero_a, rd_zero_b;
  logic wb_hit, hit_a, hit_b, issue_same, issue_set, cnt_inc, cnt_dec;

  assign wb_zero    = ZERO_REG && (bus.wb_addr == '0);
  assign issue_zero = ZERO_REG && (bus.issue_addr == '0);
  assign rd_zero_a  = ZERO_REG && (bus.rd_addr_a == '0);
  assign rd_zero_b  = ZERO_REG && (bus.rd_addr_b == '0);

  assign wb_hit     = bus.wb_en && !wb_zero;
  assign hit_a      = bus.wb_en && (bus.wb_addr == bus.rd_addr_a);
  assign hit_b      = bus.wb_en && (bus.wb_addr == bus.rd_addr_b);
  assign issue_same = bus.wb_en && (bus.wb_addr == bus.issue_addr);

  // A commit landing this cycle retires the old writer, so the new issue may proceed.
  assign bus.issue_stall = bus.issue_en && busy_q[bus.issue_addr] && !issue_same;
  assign issue_set       = bus.issue_en && !bus.issue_stall && !issue_zero;

  // Busy bit for an issue/commit collision stays set: neither term changes the count.
  assign cnt_inc = issue_set && !busy_q[bus.issue_addr];
  assign cnt_dec = wb_hit && busy_q[bus.wb_addr] && !(issue_set && issue_same);

  always_comb begin
    busy_d = busy_q;
    if (wb_hit) begin
      busy_d[bus.wb_addr] = 1'b0;
    end
    if (issue_set) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q + (ADDR_W + 1)'(cnt_inc) - (ADDR_W + 1)'(cnt_dec);
  end

  always_comb begin
    bus.rd_data_a = regs_q[bus.rd_addr_a];
    if (rd_zero_a) begin
      bus.rd_data_a = '0;
    end else if (hit_a) begin
      bus.rd_data_a = bus.wb_data;
    end
  end

  always_comb begin
    bus.rd_data_b = regs_q[bus.rd_addr_b];
    if (rd_zero_b) begin
      bus.rd_data_b = '0;
    end else if (hit_b) begin
      bus.rd_data_b = bus.wb_data;
    end
  end

  assign bus.busy_a      = busy_q[bus.rd_addr_a] && !hit_a;
  assign bus.busy_b      = busy_q[bus.rd_addr_b] && !hit_b;
  assign bus.pending_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NRegs; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wb_hit) begin
        regs_q[bus.wb_addr] <= bus.wb_data;
      end
    end
  end
endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: vector table plus reset sequences.
module tb_wb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;

  wb_regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(7)) bus ();

  wb_regfile_scoreboard #(.DATA_W(32), .ADDR_W(7), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [6:0]  wb_addr;
    logic [31:0] wb_data;
    logic [6:0]  rd_a;
    logic [6:0]  rd_b;
    logic        iss_en;
    logic [6:0]  iss_addr;
    logic [31:0] e_rd_a;
    logic [31:0] e_rd_b;
    logic        e_busy_a;
    logic        e_busy_b;
    logic        e_stall;
    logic [7:0]  e_cnt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [15];

  function automatic vec_t mk(int we, int wa, int wd, int ra, int rb, int ie, int ia,
                              int xa, int xb, int ba, int bb, int st, int cn);
    vec_t v;
    v.wb_en = 1'(we);  v.wb_addr = 7'(wa);  v.wb_data = 32'(wd);
    v.rd_a = 7'(ra);   v.rd_b = 7'(rb);
    v.iss_en = 1'(ie); v.iss_addr = 7'(ia);
    v.e_rd_a = 32'(xa); v.e_rd_b = 32'(xb);
    v.e_busy_a = 1'(ba); v.e_busy_b = 1'(bb); v.e_stall = 1'(st); v.e_cnt = 8'(cn);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input int wa, input int wd, input int ra, input int rb,
                       input logic ie, input int ia);
    bus.wb_en = we;  bus.wb_addr = 7'(wa);  bus.wb_data = 32'(wd);
    bus.rd_addr_a = 7'(ra);  bus.rd_addr_b = 7'(rb);
    bus.issue_en = ie;  bus.issue_addr = 7'(ia);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: wb_en wb_addr wb_data rd_a rd_b iss_en iss_addr |
    //          exp rd_a rd_b busy_a busy_b stall, cnt after edge
    vecs[0]  = mk(1, 5, 9,            5, 6,   0, 0,   9, 0,            0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0,            5, 0,   0, 0,   9, 0,            0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,            11, 5,  1, 11,  0, 9,            0, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0,            11, 0,  1, 11,  0, 0,            1, 0, 1, 1);
    vecs[4]  = mk(1, 11, 7,           11, 11, 0, 0,   7, 7,            0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,            11, 0,  0, 0,   7, 0,            0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0,            11, 0,  1, 11,  7, 0,            0, 0, 0, 1);
    vecs[7]  = mk(1, 11, 'hdeadbeef,  11, 11, 1, 11,  'hdeadbeef, 'hdeadbeef, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0, 0,            11, 11, 0, 0,   'hdeadbeef, 'hdeadbeef, 1, 1, 0, 1);
    vecs[9]  = mk(1, 11, 3,           11, 0,  0, 0,   3, 0,            0, 0, 0, 0);
    vecs[10] = mk(1, 0, 2,            0, 0,   1, 0,   0, 0,            0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0,            0, 0,   0, 0,   0, 0,            0, 0, 0, 0);
    vecs[12] = mk(1, 5, 100,          5, 20,  1, 20,  100, 0,          0, 0, 0, 1);
    vecs[13] = mk(1, 20, 44,          20, 21, 1, 21,  44, 0,           0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0,            21, 20, 0, 0,   0, 44,           1, 0, 0, 1);

    drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Every register reads zero and idle after reset.
    check("reset pending_cnt", 32'(bus.pending_cnt), 32'd0);
    check("reset issue_stall", 32'(bus.issue_stall), 32'd0);
    for (int i = 0; i < 128; i++) begin
      drive(1'b0, 0, 0, i, 127 - i, 1'b0, 0);
      #1;
      check($sformatf("reset rd_a[%0d]", i), bus.rd_data_a, 32'd0);
      check($sformatf("reset rd_b[%0d]", 127 - i), bus.rd_data_b, 32'd0);
      check($sformatf("reset busy_a[%0d]", i), 32'(bus.busy_a), 32'd0);
      check($sformatf("reset busy_b[%0d]", 127 - i), 32'(bus.busy_b), 32'd0);
    end
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].wb_en, int'(vecs[i].wb_addr), int'(vecs[i].wb_data),
            int'(vecs[i].rd_a), int'(vecs[i].rd_b), vecs[i].iss_en, int'(vecs[i].iss_addr));
      #1;
      check($sformatf("v%0d rd_data_a", i), bus.rd_data_a, vecs[i].e_rd_a);
      check($sformatf("v%0d rd_data_b", i), bus.rd_data_b, vecs[i].e_rd_b);
      check($sformatf("v%0d busy_a", i), 32'(bus.busy_a), 32'(vecs[i].e_busy_a));
      check($sformatf("v%0d busy_b", i), 32'(bus.busy_b), 32'(vecs[i].e_busy_b));
      check($sformatf("v%0d issue_stall", i), 32'(bus.issue_stall), 32'(vecs[i].e_stall));
      tick();
      check($sformatf("v%0d pending_cnt", i), 32'(bus.pending_cnt), 32'(vecs[i].e_cnt));
    end

    // Register 21 is still busy; add 1, 2, 3 then reset mid-flight.
    for (int a = 1; a <= 3; a++) begin
      drive(1'b0, 0, 0, 0, 0, 1'b1, a);
      tick();
      check($sformatf("issue %0d pending_cnt", a), 32'(bus.pending_cnt), 32'(a + 1));
    end
    // Reset wins over a simultaneous issue and commit.
    drive(1'b1, 21, 77, 0, 0, 1'b1, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
    check("midrst pending_cnt", 32'(bus.pending_cnt), 32'd0);
    foreach (vecs[k]) begin
      if (k < 5) begin
        int addrs [5] = '{1, 2, 3, 4, 21};
        drive(1'b0, 0, 0, addrs[k], 5, 1'b0, 0);
        #1;
        check($sformatf("midrst busy[%0d]", addrs[k]), 32'(bus.busy_a), 32'd0);
        check($sformatf("midrst rd[%0d]", addrs[k]), bus.rd_data_a, 32'd0);
        check("midrst rd[5]", bus.rd_data_b, 32'd0);
      end
    end
    drive(1'b0, 0, 0, 0, 0, 1'b1, 2);
    #1;
    check("midrst reissue stall", 32'(bus.issue_stall), 32'd0);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 0);

    // Commit to a register whose busy mark was dropped by reset: no underflow.
    drive(1'b1, 2, 5, 2, 0, 1'b0, 0);
    #1;
    check("post-rst bypass rd", bus.rd_data_a, 32'd5);
    tick();
    drive(1'b0, 0, 0, 2, 0, 1'b0, 0);
    #1;
    check("post-rst rd", bus.rd_data_a, 32'd5);
    check("post-rst pending_cnt", 32'(bus.pending_cnt), 32'd0);
    tick();
    check("post-rst pending_cnt hold", 32'(bus.pending_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
